// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: state encoding, product codes, prices.
package vend_pkg;

  localparam int CREDIT_W = 4;

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  localparam logic [1:0] GRANOLA = 2'b00;
  localparam logic [1:0] CHIPS   = 2'b01;
  localparam logic [1:0] CANDY   = 2'b10;
  localparam logic [1:0] GUM     = 2'b11;

  localparam logic [2:0] COIN_MAX = 3'd4;

  function automatic logic [CREDIT_W-1:0] price(input logic [1:0] code);
    case (code)
      GRANOLA: price = 4'd4;
      CHIPS:   price = 4'd3;
      CANDY:   price = 4'd2;
      GUM:     price = 4'd1;
      default: price = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Inactivity counter: counts enabled cycles, flags expire on the last one and wraps to 0.
module vend_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count;

  assign expire = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, price check, dispense handshake, one change pulse per unit.
// All outputs registered; dispense_valid holds until dispense_ready.
module vend_controller import vend_pkg::*; #(
  parameter int MAX_CREDIT     = 15,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TMR_W          = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [2:0]          coin_value,
  input  logic                sel_valid,
  input  logic [1:0]          sel_choice,
  input  logic                cancel,
  input  logic                dispense_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense_valid,
  output logic [1:0]          dispense_item,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                sel_denied,
  output logic                busy
);

  localparam logic [CREDIT_W:0] MAX_SUM = MAX_CREDIT[CREDIT_W:0];

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [1:0]          item_nxt;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_hit, coin_accept, sel_accept;
  logic                pulse_nxt, reject_nxt, denied_nxt;
  logic                timer_clear, timer_expire;

  assign timer_clear = (state != COLLECT) || coin_accept || sel_valid;

  vend_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .enable(state == COLLECT),
    .expire(timer_expire)
  );

  always_comb begin
    state_nxt   = state;
    credit_nxt  = credit;
    item_nxt    = dispense_item;
    pulse_nxt   = 1'b0;
    coin_accept = 1'b0;
    sel_accept  = 1'b0;
    coin_hit    = coin_valid && (coin_value != 3'd0);
    coin_sum    = {1'b0, credit} + {2'b00, coin_value};

    case (state)
      IDLE: begin
        if (!cancel && !sel_valid && coin_hit && coin_value <= COIN_MAX) begin
          coin_accept = 1'b1;
          credit_nxt  = CREDIT_W'(coin_value);
          state_nxt   = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_nxt = CHANGE;
        end else if (sel_valid) begin
          if (credit >= price(sel_choice)) begin
            sel_accept = 1'b1;
            credit_nxt = credit - price(sel_choice);
            item_nxt   = sel_choice;
            state_nxt  = VEND;
          end
        end else if (coin_hit && coin_value <= COIN_MAX && coin_sum <= MAX_SUM) begin
          coin_accept = 1'b1;
          credit_nxt  = coin_sum[CREDIT_W-1:0];
        end
        // Inactivity refund only when nothing else moved the machine this cycle.
        if (!cancel && !sel_valid && !coin_accept && timer_expire) begin
          state_nxt = CHANGE;
        end
      end
      VEND: begin
        if (dispense_valid && dispense_ready) begin
          state_nxt = (credit != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        if (credit != '0) begin
          pulse_nxt  = 1'b1;
          credit_nxt = credit - 4'd1;
          if (credit == 4'd1) state_nxt = IDLE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    reject_nxt = coin_hit && !coin_accept;
    denied_nxt = sel_valid && !sel_accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      credit         <= '0;
      dispense_item  <= GRANOLA;
      dispense_valid <= 1'b0;
      change_pulse   <= 1'b0;
      coin_reject    <= 1'b0;
      sel_denied     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      credit         <= credit_nxt;
      dispense_item  <= item_nxt;
      dispense_valid <= (state_nxt == VEND);
      change_pulse   <= pulse_nxt;
      coin_reject    <= reject_nxt;
      sel_denied     <= denied_nxt;
      busy           <= (state_nxt == VEND) || (state_nxt == CHANGE);
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: flag-based behavioural model checked every cycle plus directed literals.
module tb_vend_controller;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_valid = 1'b0;
  logic [2:0] coin_value = 3'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_choice = 2'd0;
  logic       cancel = 1'b0;
  logic       dispense_ready = 1'b0;
  logic [3:0] credit;
  logic       dispense_valid;
  logic [1:0] dispense_item;
  logic       change_pulse;
  logic       coin_reject;
  logic       sel_denied;
  logic       busy;

  int checks = 0;
  int failures = 0;

  vend_controller #(.MAX_CREDIT(15), .TIMEOUT_CYCLES(TO), .TMR_W(4)) dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_choice(sel_choice), .cancel(cancel),
    .dispense_ready(dispense_ready), .credit(credit), .dispense_valid(dispense_valid),
    .dispense_item(dispense_item), .change_pulse(change_pulse), .coin_reject(coin_reject),
    .sel_denied(sel_denied), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a session is either collecting, waiting on the actuator, or refunding.
  bit       m_collect = 0, m_vend = 0, m_refund = 0;
  int       m_idle = 0, m_credit = 0;
  bit [1:0] m_item = 0;
  bit       m_pulse = 0, m_rej = 0, m_den = 0;

  function automatic int price_of(input bit [1:0] c);
    return 4 - int'(c);
  endfunction

  task automatic model_step();
    bit coin, coin_taken, sel_taken;
    coin = coin_valid && coin_value != 0;
    coin_taken = 0;
    sel_taken = 0;
    if (reset) begin
      m_collect = 0; m_vend = 0; m_refund = 0; m_idle = 0; m_credit = 0;
      m_item = 0; m_pulse = 0; m_rej = 0; m_den = 0;
      return;
    end
    m_pulse = 0;
    if (m_refund) begin
      if (m_credit > 0) begin m_pulse = 1; m_credit = m_credit - 1; end
      if (m_credit == 0) m_refund = 0;
    end else if (m_vend) begin
      if (dispense_ready) begin m_vend = 0; m_refund = (m_credit > 0); end
    end else if (m_collect) begin
      if (cancel) begin
        m_collect = 0; m_refund = 1;
      end else if (sel_valid) begin
        m_idle = 0;
        if (m_credit >= price_of(sel_choice)) begin
          sel_taken = 1; m_credit = m_credit - price_of(sel_choice);
          m_item = sel_choice; m_collect = 0; m_vend = 1;
        end
      end else if (coin && coin_value <= 4 && m_credit + int'(coin_value) <= 15) begin
        coin_taken = 1; m_credit = m_credit + int'(coin_value); m_idle = 0;
      end else if (m_idle == TO - 1) begin
        m_idle = 0; m_collect = 0; m_refund = 1;
      end else begin
        m_idle++;
      end
    end else if (!cancel && !sel_valid && coin && coin_value <= 4) begin
      coin_taken = 1; m_credit = int'(coin_value); m_collect = 1; m_idle = 0;
    end
    m_rej = coin && !coin_taken;
    m_den = sel_valid && !sel_taken;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("credit", credit, m_credit);
    chk("dispense_valid", dispense_valid, m_vend);
    chk("dispense_item", dispense_item, m_item);
    chk("change_pulse", change_pulse, m_pulse);
    chk("coin_reject", coin_reject, m_rej);
    chk("sel_denied", sel_denied, m_den);
    chk("busy", busy, m_vend || m_refund);
  end

  task automatic apply(input bit cv, input int cval, input bit sv, input int sc,
                       input bit cn, input bit rdy);
    coin_valid = cv; coin_value = 3'(cval); sel_valid = sv; sel_choice = 2'(sc);
    cancel = cn; dispense_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic run_count(input int n, input bit rdy, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      apply(0, 0, 0, 0, 0, rdy);
      pulses += int'(change_pulse);
    end
  endtask

  initial begin
    int p;
    apply(0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    chk("reset_credit", credit, 0);
    chk("reset_busy", busy, 0);
    chk("reset_dv", dispense_valid, 0);
    reset = 1'b0;

    // coin_valid with value 0 is not a coin
    apply(1, 0, 0, 0, 0, 0);
    chk("zero_coin_reject", coin_reject, 0);
    chk("zero_coin_credit", credit, 0);

    // coin 4, chips, one change pulse
    apply(1, 4, 0, 0, 0, 0);
    chk("t1_credit4", credit, 4);
    apply(0, 0, 1, 1, 0, 0);
    chk("t1_credit1", credit, 1);
    chk("t1_dv", dispense_valid, 1);
    chk("t1_item", dispense_item, 1);
    run_count(5, 1, p);
    chk("t1_pulses", p, 1);
    chk("t1_end_credit", credit, 0);
    chk("t1_end_busy", busy, 0);

    // insufficient credit, then cancel
    apply(1, 1, 0, 0, 0, 0);
    apply(0, 0, 1, 0, 0, 0);
    chk("t2_denied", sel_denied, 1);
    chk("t2_credit", credit, 1);
    apply(0, 0, 0, 0, 1, 0);
    run_count(4, 0, p);
    chk("t2_pulses", p, 1);
    chk("t2_busy", busy, 0);

    // credit ceiling
    for (int i = 0; i < 3; i++) apply(1, 4, 0, 0, 0, 0);
    chk("t3_credit12", credit, 12);
    apply(1, 4, 0, 0, 0, 0);
    chk("t3_reject", coin_reject, 1);
    chk("t3_credit_hold", credit, 12);
    apply(1, 3, 0, 0, 0, 0);
    chk("t3_credit15", credit, 15);
    apply(0, 0, 0, 0, 1, 0);
    run_count(17, 0, p);
    chk("t3_pulses", p, 15);

    // stalled actuator
    apply(1, 2, 0, 0, 0, 0);
    apply(0, 0, 1, 2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(i == 2, 1, 0, 0, 0, 0);
      chk("t4_dv_hold", dispense_valid, 1);
      chk("t4_item_hold", dispense_item, 2);
      if (i == 2) chk("t4_coin_reject", coin_reject, 1);
    end
    run_count(4, 1, p);
    chk("t4_pulses", p, 0);
    chk("t4_dv_drop", dispense_valid, 0);
    chk("t4_busy", busy, 0);

    // inactivity timeout
    apply(1, 3, 0, 0, 0, 0);
    for (int i = 0; i < TO - 1; i++) apply(0, 0, 0, 0, 0, 0);
    chk("t5_pre_timeout_busy", busy, 0);
    apply(0, 0, 0, 0, 0, 0);
    chk("t5_change_entered", busy, 1);
    chk("t5_credit", credit, 3);
    run_count(4, 0, p);
    chk("t5_pulses", p, 3);

    // selection beats coin in the same cycle
    apply(1, 2, 0, 0, 0, 0);
    apply(1, 1, 1, 3, 0, 0);
    chk("t6_coin_lost", coin_reject, 1);
    chk("t6_credit", credit, 1);
    run_count(4, 1, p);
    chk("t6_pulses", p, 1);

    // cancel beats selection, then reset mid-refund
    apply(1, 4, 0, 0, 0, 0);
    apply(0, 0, 1, 3, 1, 0);
    chk("t7_denied", sel_denied, 1);
    chk("t7_no_dispense", dispense_valid, 0);
    apply(0, 0, 0, 0, 0, 0);
    chk("t7_pulse1", change_pulse, 1);
    chk("t7_credit3", credit, 3);
    apply(0, 0, 0, 0, 0, 0);
    chk("t7_credit2", credit, 2);
    reset = 1'b1;
    apply(0, 0, 0, 0, 0, 0);
    chk("t7_reset_credit", credit, 0);
    chk("t7_reset_pulse", change_pulse, 0);
    chk("t7_reset_busy", busy, 0);
    reset = 1'b0;
    run_count(3, 0, p);
    chk("t7_no_more_pulses", p, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
